// File: rtl/lfsr_ctrl.sv
// rtl/lfsr_ctrl.sv - region controller between an LFSR generator and a DES message port
// Sequences one seeded region at a time through a 2-entry skid buffer with a seed-wrap filter.
module lfsr_ctrl #(
  parameter int N     = 64,
  parameter int CNT_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [N-1:0]     seed_in,
  output logic             busy,
  output logic             region_done,
  output logic [CNT_W-1:0] enc_count,
  output logic             lfsr_start,
  output logic             lfsr_pause,
  output logic             lfsr_reset_counter,
  output logic [N-1:0]     lfsr_seed,
  input  logic             lfsr_valid,
  input  logic             lfsr_done,
  input  logic [N-1:0]     lfsr_data,
  output logic             msg_valid,
  output logic [N-1:0]     msg_data,
  input  logic             msg_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t         state, state_nx;
  logic [1:0]     clr_cnt;
  logic [N-1:0]   seed_q;
  logic [N-1:0]   mem [2];
  logic           rd_ptr, wr_ptr;
  logic [1:0]     count;
  logic           wrote_any;
  logic           start_acc, abort_acc, push, pop;

  always_comb begin
    start_acc = (state == S_IDLE) && cmd_start;
    abort_acc = cmd_abort && (state inside {S_LOAD, S_RUN, S_DRAIN});
    pop       = (count != 2'd0) && msg_ready;
    // The generator's own seed reappearing marks the wrap; drop it once the region has produced data.
    push      = (state == S_RUN) && lfsr_valid && !abort_acc
                && !(wrote_any && (lfsr_data == seed_q))
                && ((count != 2'd2) || pop);
  end

  always_comb begin
    state_nx    = state;
    region_done = 1'b0;
    case (state)
      S_IDLE:  if (cmd_start) state_nx = S_LOAD;
      S_LOAD:  state_nx = abort_acc ? S_CLEAR : S_RUN;
      S_RUN: begin
        if (abort_acc)      state_nx = S_CLEAR;
        else if (lfsr_done) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_acc) begin
          state_nx = S_CLEAR;
        end else if (count == 2'd0) begin
          state_nx    = S_CLEAR;
          region_done = 1'b1;
        end
      end
      S_CLEAR: if (clr_cnt == 2'd2) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= 2'd0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q    <= '0;
      wrote_any <= 1'b0;
      enc_count <= '0;
    end else begin
      if (start_acc) begin
        seed_q    <= seed_in;
        wrote_any <= 1'b0;
      end else if (push) begin
        wrote_any <= 1'b1;
      end
      if (start_acc)
        enc_count <= '0;
      else if (pop && (enc_count != {CNT_W{1'b1}}))
        enc_count <= enc_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (abort_acc) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lfsr_data;
  end

  always_comb begin
    busy               = (state != S_IDLE);
    lfsr_start         = (state == S_LOAD);
    lfsr_pause         = (state == S_RUN) && (count != 2'd0);
    lfsr_reset_counter = (state == S_CLEAR);
    lfsr_seed          = seed_q;
    msg_valid          = (count != 2'd0);
    msg_data           = mem[rd_ptr];
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb/tb_lfsr_ctrl.sv - self-checking bench for lfsr_ctrl with an 8-bit generator model
// Expected words come from an independent LFSR sequence model; a negedge process scores every pop.
module tb_lfsr_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_start, cmd_abort;
  logic [N-1:0]     seed_in;
  logic             busy, region_done;
  logic [CNT_W-1:0] enc_count;
  logic             lfsr_start, lfsr_pause, lfsr_reset_counter;
  logic [N-1:0]     lfsr_seed;
  logic             lfsr_valid, lfsr_done;
  logic [N-1:0]     lfsr_data;
  logic             msg_valid;
  logic [N-1:0]     msg_data;
  logic             msg_ready;

  lfsr_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .seed_in(seed_in), .busy(busy), .region_done(region_done), .enc_count(enc_count),
    .lfsr_start(lfsr_start), .lfsr_pause(lfsr_pause), .lfsr_reset_counter(lfsr_reset_counter),
    .lfsr_seed(lfsr_seed), .lfsr_valid(lfsr_valid), .lfsr_done(lfsr_done), .lfsr_data(lfsr_data),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Generator model: sees pause one cycle late, so it emits one extra word when pause first rises.
  logic       gen_run, gen_pause_q;
  logic [7:0] gen_cur;
  int         gen_cnt;
  int         gen_total = 256;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_run <= 1'b0; gen_pause_q <= 1'b0; gen_cur <= 8'h00; gen_cnt <= 0;
    end else begin
      gen_pause_q <= lfsr_pause;
      if (lfsr_reset_counter) begin
        gen_run <= 1'b0; gen_cnt <= 0;
      end else if (lfsr_start) begin
        gen_run <= 1'b1; gen_cur <= lfsr_seed; gen_cnt <= 0;
      end else if (lfsr_valid) begin
        gen_cur <= lfsr_next(gen_cur); gen_cnt <= gen_cnt + 1;
      end
    end
  end

  assign lfsr_valid = gen_run && !gen_pause_q && (gen_cnt < gen_total);
  assign lfsr_done  = gen_run && (gen_cnt >= gen_total);
  assign lfsr_data  = gen_cur;

  logic [7:0] exp_q[$];
  int         exp_idx  = 0;
  int         mdl_pops = 0;
  int         done_cnt = 0;
  logic       acc_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_pops = 0; acc_prev = 1'b0; exp_q.delete(); exp_idx = 0;
    end else begin
      chk("enc_count", 64'(enc_count), 64'(mdl_pops));
      chk("lfsr_start_only_load", 64'(lfsr_start), 64'(acc_prev));
      if (lfsr_pause && !msg_valid) chk("pause_without_data", 64'(lfsr_pause), 64'd0);
      if (region_done) done_cnt++;
      if (msg_valid && msg_ready) begin
        if (exp_idx < exp_q.size()) chk("msg_data", 64'(msg_data), 64'(exp_q[exp_idx]));
        else chk("extra_word", 64'(msg_data), 64'hFFFF_FFFF);
        exp_idx++;
        mdl_pops++;
      end
      acc_prev = cmd_start && !busy;
      if (acc_prev) begin
        logic [7:0] x;
        exp_q.delete(); exp_idx = 0; mdl_pops = 0;
        x = seed_in;
        for (int i = 0; i < gen_total; i++) begin
          if (i > 0 && x == seed_in) break;
          exp_q.push_back(x);
          x = lfsr_next(x);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_low(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_region_done"}, 64'(region_done), 64'd0);
    chk({tag, "_msg_valid"}, 64'(msg_valid), 64'd0);
    chk({tag, "_lfsr_start"}, 64'(lfsr_start), 64'd0);
    chk({tag, "_lfsr_pause"}, 64'(lfsr_pause), 64'd0);
    chk({tag, "_reset_counter"}, 64'(lfsr_reset_counter), 64'd0);
    chk({tag, "_enc_count"}, 64'(enc_count), 64'd0);
    chk({tag, "_lfsr_seed"}, 64'(lfsr_seed), 64'd0);
  endtask

  task automatic start_region(input logic [7:0] s, input int tot);
    gen_total = tot; seed_in = s; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; seed_in = ~s;
    chk("load_lfsr_start", 64'(lfsr_start), 64'd1);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_seed", 64'(lfsr_seed), 64'(s));
  endtask

  int max_occ, pause_bad;

  task automatic wait_region_done(input int budget, input bit rand_ready);
    bit found = 1'b0;
    max_occ = 0; pause_bad = 0;
    for (int n = 0; n < budget; n++) begin
      if (region_done) begin found = 1'b1; break; end
      if (gen_cnt < gen_total && (gen_cnt - mdl_pops) > max_occ) max_occ = gen_cnt - mdl_pops;
      if (gen_run && !lfsr_done && (lfsr_pause != msg_valid)) pause_bad++;
      if (rand_ready) msg_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (!found) chk("region_done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic check_clear();
    for (int i = 0; i < 3; i++) begin
      chk("clear_reset_counter", 64'(lfsr_reset_counter), 64'd1);
      chk("clear_pause", 64'(lfsr_pause), 64'd0);
      chk("clear_start", 64'(lfsr_start), 64'd0);
      chk("clear_busy", 64'(busy), 64'd1);
      tick();
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_reset_counter", 64'(lfsr_reset_counter), 64'd0);
  endtask

  task automatic wait_gen_done(input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (lfsr_done) begin found = 1'b1; break; end
      tick();
    end
    if (!found) chk("lfsr_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [7:0] x;
    int d0, e0, per;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; seed_in = '0; msg_ready = 1'b0;

    x = 8'h01;
    for (int i = 0; i < 4; i++) x = lfsr_next(x);
    chk("model_step4", 64'(x), 64'h11);
    x = 8'h01; per = 0;
    do begin x = lfsr_next(x); per++; end while (x != 8'h01 && per < 300);
    chk("model_period", 64'(per), 64'd255);

    #1 chk_outputs_low("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_outputs_low("post_reset");

    // Full period, ready held high: every word once, wrap dropped.
    msg_ready = 1'b1; d0 = done_cnt;
    start_region(8'h01, 256);
    wait_region_done(3000, 1'b0);
    check_clear();
    chk("r1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("r1_enc_count", 64'(enc_count), 64'd255);
    chk("r1_words_popped", 64'(exp_idx), 64'd255);
    chk("r1_seed_stable", 64'(lfsr_seed), 64'h01);

    // Random backpressure.
    d0 = done_cnt;
    start_region(8'h5A, 256);
    wait_region_done(6000, 1'b1);
    msg_ready = 1'b1;
    check_clear();
    chk("r2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("r2_enc_count", 64'(enc_count), 64'd255);
    chk("r2_words_popped", 64'(exp_idx), 64'd255);
    chk("r2_max_occupancy_le2", 64'(max_occ <= 2), 64'd1);
    chk("r2_pause_tracks_count", 64'(pause_bad), 64'd0);

    // Long stall: two words buffered, generator held, then drain in order.
    start_region(8'h33, 256);
    repeat (6) tick();
    msg_ready = 1'b0;
    repeat (20) tick();
    chk("stall_occupancy", 64'(gen_cnt - mdl_pops), 64'd2);
    chk("stall_pause", 64'(lfsr_pause), 64'd1);
    chk("stall_gen_valid", 64'(lfsr_valid), 64'd0);
    chk("stall_msg_valid", 64'(msg_valid), 64'd1);
    chk("stall_head", 64'(msg_data), 64'(exp_q[exp_idx]));
    msg_ready = 1'b1;
    wait_region_done(3000, 1'b0);
    check_clear();
    chk("r3_enc_count", 64'(enc_count), 64'd255);

    // Abort in RUN with a full buffer.
    start_region(8'h77, 256);
    repeat (6) tick();
    msg_ready = 1'b0;
    repeat (20) tick();
    chk("abort_occupancy", 64'(gen_cnt - mdl_pops), 64'd2);
    d0 = done_cnt; e0 = mdl_pops;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_msg_valid", 64'(msg_valid), 64'd0);
    check_clear();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_enc_frozen", 64'(enc_count), 64'(e0));

    // lfsr_done and cmd_abort in the same cycle.
    msg_ready = 1'b1;
    start_region(8'h01, 5);
    wait_gen_done(200);
    chk("race_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    cmd_abort = 1'b1; msg_ready = 1'b0;
    tick();
    cmd_abort = 1'b0;
    chk("race_msg_valid", 64'(msg_valid), 64'd0);
    check_clear();
    chk("race_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset during DRAIN, then restart with seed 0xA5.
    msg_ready = 1'b0;
    start_region(8'h3C, 2);
    wait_gen_done(200);
    repeat (2) tick();
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_msg_valid", 64'(msg_valid), 64'd1);
    chk("drain_enc_count", 64'(enc_count), 64'd0);
    rst_n = 1'b0;
    #1 chk_outputs_low("mid_drain_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle_busy", 64'(busy), 64'd0);
    chk("post_reset_idle_valid", 64'(msg_valid), 64'd0);
    msg_ready = 1'b1; d0 = done_cnt;
    start_region(8'hA5, 5);
    chk("a5_enc_restart", 64'(enc_count), 64'd0);
    wait_region_done(500, 1'b0);
    check_clear();
    chk("a5_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("a5_enc_count", 64'(enc_count), 64'd5);
    chk("a5_words_popped", 64'(exp_idx), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter N, default 64: LFSR/message width.
REQ-002 Parameter CNT_W, default 40: width of the encryption counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cmd_start  input  1  host request to run one region; sampled only in IDLE.
REQ-006 cmd_abort  input  1  host request to stop the current region; ignored in IDLE and CLEAR.
REQ-007 seed_in  input  N  region seed; latched when cmd_start is accepted.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 region_done  output  1  one-cycle pulse when a region completes normally.
REQ-010 enc_count  output  CNT_W  number of messages accepted downstream in the current or last region.
REQ-011 lfsr_start, lfsr_pause, lfsr_reset_counter  output  1 each  control lines to the LFSR generator.
REQ-012 lfsr_seed  output  N  seed register value, driven to the generator.
REQ-013 lfsr_valid, lfsr_done  input  1 each  generator status lines.
REQ-014 lfsr_data  input  N  generator output word.
REQ-015 msg_valid  output  1, msg_data  output  N, msg_ready  input  1  downstream valid/ready message port to the DES core.

Function
REQ-016 FSM states: IDLE, LOAD, RUN, DRAIN, CLEAR.
REQ-017 IDLE: on cmd_start=1, latch seed_in into the seed register, clear enc_count, and enter LOAD.
REQ-018 LOAD lasts exactly 1 cycle, drives lfsr_start=1, and then enters RUN.
REQ-019 lfsr_seed SHALL stay stable from the LOAD cycle until the next accepted cmd_start.
REQ-020 Skid buffer: 2-entry FIFO; lfsr_valid=1 in RUN writes lfsr_data, subject to the filter below.
REQ-021 Wrap filter: a word equal to the seed register SHALL be discarded if at least one word of this region has already been written.
REQ-022 lfsr_pause = (FIFO count != 0) in RUN; lfsr_pause=0 in all other states.
REQ-023 Depth 2 absorbs the one extra word the generator emits in the cycle pause is first seen; that write SHALL never be lost or overflow.
REQ-024 msg_valid = FIFO non-empty; msg_data = FIFO head word.
REQ-025 Pop occurs on msg_valid&&msg_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 enc_count increments on each pop and saturates at all-ones.
REQ-027 RUN -> DRAIN when lfsr_done=1.
REQ-028 DRAIN -> CLEAR when the FIFO is empty, with region_done=1 in that transition cycle.
REQ-029 CLEAR lasts exactly 3 cycles with lfsr_reset_counter=1, lfsr_pause=0, lfsr_start=0, then returns to IDLE.
REQ-030 In CLEAR, incoming lfsr_valid words are discarded.
REQ-031 cmd_abort=1 in LOAD, RUN or DRAIN: flush the FIFO (msg_valid=0 next cycle), enter CLEAR, no region_done pulse, enc_count holds.
REQ-032 cmd_abort has priority over lfsr_done and over FIFO-empty completion in the same cycle.
REQ-033 cmd_start is ignored while busy=1.
REQ-034 lfsr_start=1 only in LOAD.

Reset
REQ-035 rst_n=0 forces, immediately: state IDLE, FIFO empty, seed register 0, enc_count 0.
REQ-036 rst_n=0 forces all outputs low: busy, region_done, msg_valid, lfsr_start, lfsr_pause, lfsr_reset_counter.
REQ-037 Reset asserted mid-region discards all buffered words; operation restarts only on a new cmd_start.

Verification
REQ-038 Seed 0x1, N=8 generator model, msg_ready tied 1 -> every word emitted exactly once; seed not duplicated at wrap; one region_done; enc_count equals period; then 3 CLEAR cycles, busy=0.
REQ-039 msg_ready toggling randomly 50% -> no word lost, duplicated or reordered; FIFO count never exceeds 2; lfsr_pause high exactly while count != 0.
REQ-040 msg_ready=0 for 20 cycles in RUN -> exactly 2 words buffered, generator paused; release -> words drain in order.
REQ-041 cmd_abort in RUN with 2 words buffered -> msg_valid=0 next cycle, lfsr_reset_counter high 3 cycles with pause=0, no region_done, enc_count frozen.
REQ-042 lfsr_done and cmd_abort asserted in the same cycle -> abort path taken, no region_done.
REQ-043 rst_n pulsed low mid-DRAIN -> outputs low immediately; new cmd_start with seed 0xA5 -> enc_count restarts from 0.
